// File: rtl/mult_div_unit_if.sv
// Interface bundling the request/result signals of mult_div_unit.
// master: the issuing side (pipeline or testbench); slave: the unit itself.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit (MULTU, MULT, DIVU, DIV).
// One partial product or one quotient bit per cycle, 32 iterations.
// Signed ops run on magnitudes; the sign is fixed up on the way into DONE.
// Define MULTDIV_DIV_EN to build the restoring divider; without it the
// divide opcodes complete immediately with a zero result.
module mult_div_unit (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        sign_q;

`ifdef MULTDIV_DIV_EN
    logic        is_div;
    logic        sign_r;
    logic        dbz_r;
    logic [31:0] a_r;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
`endif

    logic [32:0] mul_sum;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod;
    logic [63:0] prod_neg;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        accept;

    assign accept = bus.start && (state != RUN);

    // Operand magnitudes at the accept edge; op[0] marks the signed variants
    always_comb begin
        a_mag = (bus.op[0] && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        b_mag = (bus.op[0] && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    end

    // One iteration step: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : 33'd0);
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], p_lo[31:1]};
`ifdef MULTDIV_DIV_EN
        div_shift = {p_hi, p_lo[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand};
        if (is_div) begin
            if (!div_diff[33]) begin
                step_hi = div_diff[31:0];
                step_lo = {p_lo[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {p_lo[30:0], 1'b0};
            end
        end
`endif
    end

    // Sign-corrected final result, consumed on the last RUN cycle
    always_comb begin
        prod             = {step_hi, step_lo};
        prod_neg         = 64'd0 - prod;
        {res_hi, res_lo} = sign_q ? prod_neg : prod;
`ifdef MULTDIV_DIV_EN
        if (is_div) begin
            res_lo = sign_q ? (32'd0 - step_lo) : step_lo;
            res_hi = sign_r ? (32'd0 - step_hi) : step_hi;
            // Zero divisor: fixed all-ones quotient, dividend returned as-is
            if (dbz_r) begin
                res_lo = '1;
                res_hi = a_r;
            end
        end
`endif
    end

    // Control FSM with registered outputs and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            mcand           <= '0;
            p_hi            <= '0;
            p_lo            <= '0;
            sign_q          <= 1'b0;
`ifdef MULTDIV_DIV_EN
            is_div          <= 1'b0;
            sign_r          <= 1'b0;
            dbz_r           <= 1'b0;
            a_r             <= '0;
`endif
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    if (accept) begin
                        cnt    <= '0;
                        p_hi   <= '0;
                        sign_q <= bus.op[0] & (bus.a[31] ^ bus.b[31]);
`ifdef MULTDIV_DIV_EN
                        is_div <= bus.op[1];
                        sign_r <= bus.op[0] & bus.a[31];
                        dbz_r  <= (bus.b == 32'd0);
                        a_r    <= bus.a;
                        // Divide: dividend shifts out of p_lo, divisor is mcand
                        if (bus.op[1]) begin
                            mcand <= b_mag;
                            p_lo  <= a_mag;
                        end else begin
                            mcand <= a_mag;
                            p_lo  <= b_mag;
                        end
                        state    <= RUN;
                        bus.busy <= 1'b1;
`else
                        if (bus.op[1]) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.hi          <= '0;
                            bus.lo          <= '0;
                            bus.div_by_zero <= 1'b0;
                        end else begin
                            mcand    <= a_mag;
                            p_lo     <= b_mag;
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    p_hi <= step_hi;
                    p_lo <= step_lo;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.hi   <= res_hi;
                        bus.lo   <= res_lo;
`ifdef MULTDIV_DIV_EN
                        bus.div_by_zero <= is_div & dbz_r;
`else
                        bus.div_by_zero <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
